led_pwm_dimmer: RTL

- PWM LED dimmer stage; sits directly downstream of the clock-enable divider and consumes its one-cycle-per-N-clocks tick as the PWM count enable.
- Generates a glitch-free PWM drive for an LED with a duty level that is either loaded by the host (manual mode) or ramped automatically (breathe mode).
- Duty changes take effect only at PWM period boundaries.

---
 rtl/led_pwm_dimmer_if.sv | 24 ++
 rtl/led_pwm_dimmer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/led_pwm_dimmer_if.sv
// Host-side bundle for the LED PWM dimmer: divider tick, duty/mode
// controls in, PWM drive and debug observables out.
interface led_pwm_dimmer_if #(
    parameter int WIDTH = 8
);
    logic             tick;
    logic             mode;
    logic [WIDTH-1:0] duty_in;
    logic             duty_load;
    logic             pwm_out;
    logic [WIDTH-1:0] duty_cur;
    logic             period_end;
    logic [2:0]       state;

    modport master (
        output tick, mode, duty_in, duty_load,
        input  pwm_out, duty_cur, period_end, state
    );

    modport slave (
        input  tick, mode, duty_in, duty_load,
        output pwm_out, duty_cur, period_end, state
    );
endinterface

// File: rtl/led_pwm_dimmer.sv
// PWM LED dimmer. A free-running WIDTH-bit counter advances on each divider
// tick; the LED is on while cnt < duty. The applied duty only changes at the
// period wrap, either from the host shadow (manual) or from a breathe ramp
// that climbs, holds at full, falls, holds at zero and repeats.
module led_pwm_dimmer #(
    parameter int WIDTH        = 8,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_PERIODS = 16
) (
    input  logic             clk,
    input  logic             rst,
    led_pwm_dimmer_if.slave  bus
);
    typedef enum logic [2:0] {
        MANUAL  = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    // Period counter must hold the larger of the two dwell counts.
    localparam int MAXP = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
    localparam int SW   = $clog2(MAXP + 1);

    localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_PERIODS - 1);
    localparam logic [SW-1:0]    HOLD_LAST = SW'(HOLD_PERIODS - 1);
    localparam logic [WIDTH-1:0] DMAX      = '1;
    localparam logic [WIDTH-1:0] DMAX_M1   = DMAX - 1'b1;
    localparam logic [WIDTH-1:0] DONE      = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [SW-1:0]    step_q, step_d;
    state_t           state_q, state_d;
    logic             period_end;

    assign period_end = bus.tick && (cnt_q == DMAX);

    // Next-state: counter, shadow capture and all boundary-time duty/FSM updates.
    always_comb begin
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        shadow_d = shadow_q;
        step_d   = step_q;
        state_d  = state_q;

        if (bus.tick)
            cnt_d = cnt_q + 1'b1;

        // Host loads are only meaningful while the host owns the duty.
        if (state_q == MANUAL && bus.duty_load)
            shadow_d = bus.duty_in;

        if (period_end) begin
            if (state_q == MANUAL) begin
                // A load landing on the wrap edge itself beats the shadow.
                duty_d = bus.duty_load ? bus.duty_in : shadow_q;
                if (bus.mode) begin
                    state_d = UP;
                    step_d  = '0;
                end
            end else if (!bus.mode) begin
                // Leaving breathe freezes the level and seeds the shadow with it
                // so the next manual boundary does not jump.
                state_d  = MANUAL;
                shadow_d = duty_q;
                step_d   = '0;
            end else begin
                case (state_q)
                    UP: begin
                        if (duty_q == DMAX) begin
                            state_d = HOLD_HI;
                            step_d  = '0;
                        end else if (step_q == STEP_LAST) begin
                            duty_d = duty_q + DONE;
                            step_d = '0;
                            if (duty_q == DMAX_M1)
                                state_d = HOLD_HI;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                    HOLD_HI: begin
                        if (step_q == HOLD_LAST) begin
                            state_d = DOWN;
                            step_d  = '0;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                    DOWN: begin
                        if (duty_q == '0) begin
                            state_d = HOLD_LO;
                            step_d  = '0;
                        end else if (step_q == STEP_LAST) begin
                            duty_d = duty_q - DONE;
                            step_d = '0;
                            if (duty_q == DONE)
                                state_d = HOLD_LO;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                    HOLD_LO: begin
                        if (step_q == HOLD_LAST) begin
                            state_d = UP;
                            step_d  = '0;
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = MANUAL;
                        step_d  = '0;
                    end
                endcase
            end
        end
    end

    // State registers; reset drops the LED and returns to manual at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            duty_q   <= '0;
            shadow_q <= '0;
            step_q   <= '0;
            state_q  <= MANUAL;
        end else begin
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
            step_q   <= step_d;
            state_q  <= state_d;
        end
    end

    // Drive is a pure compare of registers, so it cannot glitch mid-period.
    assign bus.pwm_out    = (cnt_q < duty_q);
    assign bus.duty_cur   = duty_q;
    assign bus.period_end = period_end;
    assign bus.state      = state_q;
endmodule
